sync_fifo_flags: RTL and testbench

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/sync_fifo_flags.sv | 137 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags -- single-clock FIFO with registered occupancy and status flags.
//
// Optional build macro: SYNC_FIFO_ERR_FLAG_EN adds sticky overflow/underflow
// error outputs. Without it those ports and their logic do not exist.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   wr, datain      write request and write data
//   rd              read request
//   dataout         registered read data, holds between reads
//   dout_valid      one-cycle pulse when dataout carries a newly read word
//   full, empty     occupancy == DEPTH / occupancy == 0
//   almost_full     count >= AF_LEVEL
//   almost_empty    count <= AE_LEVEL
//   count           occupancy, 0..DEPTH
//   overflow        (macro only) sticky: write requested while full
//   underflow       (macro only) sticky: read requested while empty

module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAG_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] PTR_ONE = PW'(1);
  localparam logic [ADDR_WIDTH:0] AF_CNT  = PW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT  = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;
  logic                  dvld_q,   dvld_d;

  logic full_c, empty_c;
  logic wr_en, rd_en;

  // Flags come only from registered pointers/count, so wr/rd never reach
  // a flag output combinationally.
  always_comb begin
    full_c  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
              (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    empty_c = (wr_ptr_q == rd_ptr_q);
    wr_en   = wr && !full_c;
    rd_en   = rd && !empty_c;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvld_d   = rd_en;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvld_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvld_q   <= dvld_d;
    end
  end

  // Storage is deliberately not reset; resetting the pointers is enough to
  // discard its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= datain;
  end

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr & full_c);
      udf_q <= udf_q | (rd & empty_c);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

  assign dataout      = dout_q;
  assign dout_valid   = dvld_q;
  assign full         = full_c;
  assign empty        = empty_c;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DATA_WIDTH=8, ADDR_WIDTH=3,
// AF_LEVEL=6, AE_LEVEL=2). Error-flag checks are active when the design is
// built with SYNC_FIFO_ERR_FLAG_EN.

module tb_sync_fifo_flags;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic [7:0] datain;
  logic       rd;
  logic [7:0] dataout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic       overflow;
  logic       underflow;
`endif

  sync_fifo_flags #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .AF_LEVEL  (6),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wr),
    .datain      (datain),
    .rd          (rd),
    .dataout     (dataout),
    .dout_valid  (dout_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count)
`ifdef SYNC_FIFO_ERR_FLAG_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stored words, expected read results, last expected dataout.
  logic [7:0] mfifo[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_udf;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mfifo.delete();
    exp_q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic chk_state(input logic exp_valid);
    int unsigned n;
    n = mfifo.size();
    chk_eq("dout_valid",   32'(dout_valid),   32'(exp_valid));
    chk_eq("dataout",      32'(dataout),      32'(m_dout));
    chk_eq("count",        32'(count),        32'(n));
    chk_eq("full",         32'(full),         32'(n == 8));
    chk_eq("empty",        32'(empty),        32'(n == 0));
    chk_eq("almost_full",  32'(almost_full),  32'(n >= 6));
    chk_eq("almost_empty", 32'(almost_empty), 32'(n <= 2));
`ifdef SYNC_FIFO_ERR_FLAG_EN
    chk_eq("overflow",     32'(overflow),     32'(m_ovf));
    chk_eq("underflow",    32'(underflow),    32'(m_udf));
`endif
  endtask

  // Called just after a falling edge: drives one cycle of stimulus, updates the
  // model, and checks the DUT after the following falling edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic wacc, racc;
    wr     = w;
    rd     = r;
    datain = d;
    wacc = w && (mfifo.size() != 8);
    racc = r && (mfifo.size() != 0);
    if (w && mfifo.size() == 8) m_ovf = 1'b1;
    if (r && mfifo.size() == 0) m_udf = 1'b1;
    if (racc) exp_q.push_back(mfifo.pop_front());
    if (wacc) mfifo.push_back(d);
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    if (exp_q.size() > 0) m_dout = exp_q.pop_front();
    chk_state(racc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    wr     = 1'b0;
    rd     = 1'b0;
    datain = 8'h00;
    model_reset();

    @(negedge clk);
    chk_state(1'b0);
    rst_n = 1'b1;

    // Fill 0x01..0x08; flag thresholds are checked on every cycle.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    // Ninth write while full is dropped.
    step(1'b1, 8'hAA, 1'b0);
    // Drain: 0x01..0x08 in order.
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    // Read while empty: no valid, dataout holds.
    step(1'b0, 8'h00, 1'b1);

    // Occupancy 4, then 20 simultaneous read/write cycles across the wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h10 + 8'(i), 1'b1);

    // Top up to full, then write+read while full: only the read happens.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);

    // Write+read while empty: only the write happens.
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset in the middle of operation with five words stored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_state(1'b0);
    @(negedge clk);
    chk_state(1'b0);
    rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
